// File: rtl/ssaes_inv_sub_bytes_seq.sv
// ssaes_inv_sub_bytes_seq
//   Sequential inverse SubBytes for Small Scale AES 4x4x4 (64-bit state,
//   16 nibbles). A state is taken over a valid/ready handshake and
//   substituted NIB_PER_CYC nibbles per clock, starting at nibble 0
//   (bits [3:0]). The result is then offered over a second handshake.
//
//   Optional macro SSAES_SBOX_FWD_MODE_EN adds a fwd input. It is sampled
//   at the input handshake and selects the forward S-box for that state.
//
//   Ports
//     clk, rst             clock, async active-high reset
//     in_valid/in_ready    input handshake (ready only in IDLE)
//     in_data[63:0]        state in, nibble i at [4i+3:4i]
//     out_valid/out_ready  output handshake (valid only in DONE)
//     out_data[63:0]       state register (meaningful while out_valid)
//     busy                 RUN or DONE
//     fwd                  forward-S-box select (macro only)

// One S-box lane. The engine instantiates NIB_PER_CYC of these.
module ssaes_isb_lane (
`ifdef SSAES_SBOX_FWD_MODE_EN
  input  logic       fwd,
`endif
  input  logic [3:0] nib,
  output logic [3:0] sub
);
  logic [3:0] inv_sub;

  always_comb begin
    inv_sub = 4'h0;
    case (nib)
      4'h0: inv_sub = 4'he;  4'h1: inv_sub = 4'hd;
      4'h2: inv_sub = 4'h4;  4'h3: inv_sub = 4'hc;
      4'h4: inv_sub = 4'h3;  4'h5: inv_sub = 4'h2;
      4'h6: inv_sub = 4'h0;  4'h7: inv_sub = 4'h6;
      4'h8: inv_sub = 4'hf;  4'h9: inv_sub = 4'h8;
      4'ha: inv_sub = 4'h7;  4'hb: inv_sub = 4'h1;
      4'hc: inv_sub = 4'hb;  4'hd: inv_sub = 4'h9;
      4'he: inv_sub = 4'h5;  default: inv_sub = 4'ha;
    endcase
  end

`ifdef SSAES_SBOX_FWD_MODE_EN
  logic [3:0] fwd_sub;

  always_comb begin
    fwd_sub = 4'h0;
    case (nib)
      4'h0: fwd_sub = 4'h6;  4'h1: fwd_sub = 4'hb;
      4'h2: fwd_sub = 4'h5;  4'h3: fwd_sub = 4'h4;
      4'h4: fwd_sub = 4'h2;  4'h5: fwd_sub = 4'he;
      4'h6: fwd_sub = 4'h7;  4'h7: fwd_sub = 4'ha;
      4'h8: fwd_sub = 4'h9;  4'h9: fwd_sub = 4'hd;
      4'ha: fwd_sub = 4'hf;  4'hb: fwd_sub = 4'hc;
      4'hc: fwd_sub = 4'h3;  4'hd: fwd_sub = 4'h1;
      4'he: fwd_sub = 4'h0;  default: fwd_sub = 4'h8;
    endcase
  end

  assign sub = fwd ? fwd_sub : inv_sub;
`else
  assign sub = inv_sub;
`endif
endmodule

module ssaes_inv_sub_bytes_seq #(
  parameter int NIB_PER_CYC = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  output logic        busy
`ifdef SSAES_SBOX_FWD_MODE_EN
  ,
  input  logic        fwd
`endif
);
  localparam int GROUPS = 16 / NIB_PER_CYC;
  localparam int CW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;

  if (!(NIB_PER_CYC == 1 || NIB_PER_CYC == 2 || NIB_PER_CYC == 4 ||
        NIB_PER_CYC == 8 || NIB_PER_CYC == 16)) begin : g_bad_param
    $error("NIB_PER_CYC must be 1, 2, 4, 8 or 16");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                        state, state_nxt;
  logic [CW-1:0]                 cnt;
  logic [63:0]                   st, st_sub;
  logic [5:0]                    bit_base;
  logic                          accept, last_grp;
  logic [NIB_PER_CYC-1:0][3:0]   lane_in, lane_out;

  // rst gates in_ready so nothing looks acceptable while reset is held.
  assign in_ready  = (state == IDLE) & ~rst;
  assign accept    = in_valid & in_ready;
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign out_data  = st;
  assign last_grp  = (cnt == CW'(GROUPS - 1));
  // For NIB_PER_CYC=16 the stride truncates to 0, but cnt is always 0 then.
  assign bit_base  = 6'(cnt) * 6'(NIB_PER_CYC * 4);

`ifdef SSAES_SBOX_FWD_MODE_EN
  logic fwd_q;
`endif

  for (genvar j = 0; j < NIB_PER_CYC; j++) begin : g_lane
    assign lane_in[j] = st[bit_base + 6'(j * 4) +: 4];
    ssaes_isb_lane u_lane (
`ifdef SSAES_SBOX_FWD_MODE_EN
      .fwd (fwd_q),
`endif
      .nib (lane_in[j]),
      .sub (lane_out[j])
    );
  end

  // Write the current group back in place; all other nibbles pass through.
  always_comb begin
    st_sub = st;
    for (int j = 0; j < NIB_PER_CYC; j++)
      st_sub[bit_base + 6'(j * 4) +: 4] = lane_out[j];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)    state_nxt = RUN;
      RUN:     if (last_grp)  state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st  <= '0;
      cnt <= '0;
`ifdef SSAES_SBOX_FWD_MODE_EN
      fwd_q <= 1'b0;
`endif
    end else if (accept) begin
      st  <= in_data;
      cnt <= '0;
`ifdef SSAES_SBOX_FWD_MODE_EN
      fwd_q <= fwd;
`endif
    end else if (state == RUN) begin
      st  <= st_sub;
      cnt <= last_grp ? '0 : cnt + CW'(1);
    end
  end
endmodule

// File: tb/tb_ssaes_inv_sub_bytes_seq.sv
// Bench for ssaes_inv_sub_bytes_seq: one instance per legal NIB_PER_CYC,
// each driven by its own directed + randomized sequence and checked against
// a table-based S-box model. A shared mid-run reset is applied to all.
module tb_ssaes_inv_sub_bytes_seq;
  localparam int NCFG    = 5;
  localparam int NSTREAM = 1000;
  localparam logic [3:0] INV_T [16] = '{4'he, 4'hd, 4'h4, 4'hc, 4'h3, 4'h2, 4'h0, 4'h6,
                                        4'hf, 4'h8, 4'h7, 4'h1, 4'hb, 4'h9, 4'h5, 4'ha};
  localparam logic [3:0] FWD_T [16] = '{4'h6, 4'hb, 4'h5, 4'h4, 4'h2, 4'he, 4'h7, 4'ha,
                                        4'h9, 4'hd, 4'hf, 4'hc, 4'h3, 4'h1, 4'h0, 4'h8};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic go  = 1'b0;
  int   n_chk = 0, n_fail = 0, n_pre = 0, n_fin = 0;

  always #5 clk = ~clk;

  function automatic logic [63:0] model(input logic [63:0] x, input bit f);
    logic [63:0] y;
    y = '0;
    for (int i = 0; i < 16; i++)
      y[4*i +: 4] = f ? FWD_T[x[4*i +: 4]] : INV_T[x[4*i +: 4]];
    return y;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic mark_pre();
    n_pre++;
  endtask

  task automatic mark_fin();
    n_fin++;
  endtask

  for (genvar gi = 0; gi < NCFG; gi++) begin : g_cfg
    localparam int N = 1 << gi;
    localparam int G = 16 / N;

    logic        iv = 1'b0, ordy = 1'b0;
    logic        ir, ov, bsy;
    logic [63:0] id = '0;
    logic [63:0] od;
`ifdef SSAES_SBOX_FWD_MODE_EN
    logic        fm = 1'b0;
`endif

    ssaes_inv_sub_bytes_seq #(.NIB_PER_CYC(N)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (iv),
      .in_ready  (ir),
      .in_data   (id),
      .out_valid (ov),
      .out_ready (ordy),
      .out_data  (od),
      .busy      (bsy)
`ifdef SSAES_SBOX_FWD_MODE_EN
      ,
      .fwd       (fm)
`endif
    );

    task automatic c(input string nm, input logic [63:0] act, input logic [63:0] exp);
      chk($sformatf("N%0d %s", N, nm), act, exp);
    endtask

    // One full transaction with out_ready asserted as soon as out_valid shows.
    task automatic xfer(input logic [63:0] din, input string nm, output logic [63:0] dout);
      int cyc;
      @(negedge clk);
      iv = 1'b1; id = din;
      cyc = 0;
      while (!ir && cyc < 50) begin @(negedge clk); cyc++; end
      c({nm, " accept"}, 64'(ir), 64'd1);
      @(negedge clk);
      iv = 1'b0;
      c({nm, " busy in run"}, 64'(bsy), 64'd1);
      c({nm, " in_ready in run"}, 64'(ir), 64'd0);
      cyc = 0;
      while (!ov && cyc < 100) begin @(negedge clk); cyc++; end
      c({nm, " latency"}, 64'(cyc), 64'(G));
      dout = od;
      c({nm, " in_ready in done"}, 64'(ir), 64'd0);
      ordy = 1'b1;
      @(negedge clk);
      ordy = 1'b0;
      c({nm, " out_valid after hs"}, 64'(ov), 64'd0);
      c({nm, " in_ready after hs"}, 64'(ir), 64'd1);
    endtask

    initial begin
      logic [63:0] d, r, prev;
      logic [63:0] q[$];
      int cyc, sent, got, acc_cyc;
      logic prev_ov;

      @(negedge clk);
      c("in_ready in reset", 64'(ir), 64'd0);
      c("out_valid in reset", 64'(ov), 64'd0);
      c("busy in reset", 64'(bsy), 64'd0);
      c("out_data in reset", od, 64'd0);
      wait (!rst);
      @(negedge clk);
      c("in_ready after reset", 64'(ir), 64'd1);

      xfer(64'h0123456789ABCDEF, "vec1", d);
      c("vec1 data", d, 64'hED4C3206F871B95A);
      xfer(64'h6B542E7A9DFC3108, "vec2", d);
      c("vec2 data", d, 64'h0123456789ABCDEF);
`ifdef SSAES_SBOX_FWD_MODE_EN
      fm = 1'b1;
      xfer(64'h0123456789ABCDEF, "fwd", d);
      c("fwd data", d, 64'h6B542E7A9DFC3108);
      fm = 1'b0;
      xfer(d, "fwd back", r);
      c("fwd back data", r, 64'h0123456789ABCDEF);
`endif

      // Back-pressure: result must sit still and ignore input pulses.
      r = {$urandom, $urandom};
      @(negedge clk);
      iv = 1'b1; id = r;
      @(negedge clk);
      iv = 1'b0;
      cyc = 0;
      while (!ov && cyc < 100) begin @(negedge clk); cyc++; end
      d = od;
      c("bp result", d, model(r, 1'b0));
      for (int k = 0; k < 10; k++) begin
        iv = 1'b1; id = {$urandom, $urandom};
        @(negedge clk);
        c("bp out_valid", 64'(ov), 64'd1);
        c("bp out_data stable", od, d);
        c("bp in_ready", 64'(ir), 64'd0);
      end
      iv = 1'b0; ordy = 1'b1;
      @(negedge clk);
      ordy = 1'b0;
      c("bp released", 64'(ov), 64'd0);
      c("bp idle in_ready", 64'(ir), 64'd1);
      @(negedge clk);
      c("bp no stray accept", 64'(bsy), 64'd0);

      // Random streaming against a queue of expected results.
      sent = 0; got = 0; cyc = 0; acc_cyc = 0; prev = od; prev_ov = ov;
      while (got < NSTREAM && cyc < 60000) begin
        @(negedge clk);
        cyc++;
        if (ov && !prev_ov) c("stream latency", 64'(cyc - acc_cyc), 64'(G + 1));
        if (ov && prev_ov)  c("stream stall stable", od, prev);
        iv   = (sent < NSTREAM) && ($urandom_range(3) != 0);
        id   = {$urandom, $urandom};
        ordy = ($urandom_range(3) != 0);
        if (iv && ir) begin
          c("stream single in flight", 64'(q.size()), 64'd0);
          q.push_back(model(id, 1'b0));
          sent++;
          acc_cyc = cyc;
        end
        if (ov && ordy) begin
          if (q.size() == 0) c("stream spurious output", 64'd1, 64'd0);
          else c($sformatf("stream out %0d", got), od, q.pop_front());
          got++;
        end
        prev = od; prev_ov = ov;
      end
      c("stream count", 64'(got), 64'(NSTREAM));
      iv = 1'b0;
      @(negedge clk);
      ordy = 1'b0;
      mark_pre();

      // Mid-flight reset, then a fresh all-ones state.
      wait (go);
      iv = 1'b1; id = {$urandom, $urandom};
      @(negedge clk);
      iv = 1'b0;
      wait (rst);
      #1;
      c("mid reset in_ready", 64'(ir), 64'd0);
      c("mid reset out_valid", 64'(ov), 64'd0);
      c("mid reset busy", 64'(bsy), 64'd0);
      c("mid reset out_data", od, 64'd0);
      wait (!rst);
      @(negedge clk);
      c("post reset in_ready", 64'(ir), 64'd1);
      xfer(64'hFFFFFFFFFFFFFFFF, "ones", d);
      c("ones data", d, 64'hAAAAAAAAAAAAAAAA);
      mark_fin();
    end
  end

  initial begin
    int w;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    w = 0;
    while (n_pre < NCFG && w < 70000) begin @(negedge clk); w++; end
    if (n_pre < NCFG) begin
      $display("FAIL stream phase timeout: %0d of %0d done", n_pre, NCFG);
      $fatal(1);
    end
    go = 1'b1;
    // Accept edge plus 7 more: the 1-nibble engine sits at counter 7.
    repeat (8) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    w = 0;
    while (n_fin < NCFG && w < 1000) begin @(negedge clk); w++; end
    chk("final phase completion", 64'(n_fin), 64'(NCFG));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
